id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode/operand stage that sits directly upstream of the 32-bit ALU in the CPU datapath. It decodes one MIPS-style instruction per cycle, reads a 32x32 register file, and selects the immediate. The results go into a registered ID/EX bundle: src1, src2, ALU_control, bonus_control, destination and write enable, which drives the ALU in the following cycle. Writeback from downstream enters through a dedicated write port, and stall/flush control comes from the hazard logic.

## Interface
- XLEN, 32: datapath width (fixed at 32; ALU is 32-bit)
- NREG, 32: register count; address width 5
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  instr carries a valid instruction this cycle
- id_ready  output  1  stage accepts instr this cycle (= ~stall)
- instr  input  32  instruction word
- stall  input  1  hold ID/EX register, do not accept instr
- flush  input  1  squash: insert bubble into ID/EX
- wb_en  input  1  register-file write enable
- wb_addr  input  5  write address
- wb_data  input  32  write data
- ex_valid  output  1  ID/EX bundle valid
- ex_src1  output  32  ALU src1 (rs value)
- ex_src2  output  32  ALU src2 (rt value or extended immediate)
- ex_alu_ctrl  output  4  ALU_control code
- ex_bonus_ctrl  output  3  bonus_control code
- ex_rd  output  5  destination register
- ex_we  output  1  destination write enable
- illegal  output  1  one-cycle pulse: undecodable instruction accepted

## Operation
- Field split: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
- R-type (op=0), src2=R[rt], dest=rd, each funct maps to an ALU_control/bonus_control pair:
  - 0x20 add: 0010/000
  - 0x22 sub: 0110/000
  - 0x24 and: 0000/000
  - 0x25 or: 0001/000
  - 0x27 nor: 1100/000
  - 0x2A slt: 0111/000
  - 0x2B sltu: 0111/101
- I-type, dest=rt:
  - 0x08 addi: 0010, src2 sign-extended imm
  - 0x0A slti: 0111/000, sign-extended imm
  - 0x0C andi: 0000, zero-extended imm
  - 0x0D ori: 0001, zero-extended imm
- Any other op/funct: illegal. Bubble loaded (ex_valid=0, ex_we=0); illegal pulses for one cycle.
- ex_we=0 when dest=0.
- Register file:
  - R[0] reads 0 always; writes to address 0 are ignored.
  - Writes take effect on the clk edge when wb_en=1.
- Same-cycle bypass: if wb_en and wb_addr==rs (or rt), nonzero, the read returns wb_data (write-before-read).

## Timing
- Reset (rst_n=0, asynchronous): all ID/EX outputs 0, illegal=0, all registers 0. id_ready follows ~stall combinationally.
- Latency: instr accepted at edge N appears on ex_* after edge N; ALU result is available in cycle N+1.
- Per-edge priority:
  - flush=1: ex_valid<=0, ex_we<=0; other ex_* fields don't-care (driven 0).
  - else stall=1: all ex_* hold; instr is not consumed; illegal stays 0.
  - else id_valid=1: load the decoded bundle.
  - else: load a bubble.
- Flush and stall together: flush wins, and instr is still not consumed.
- Register writes are never blocked by stall or flush.
- Operand read uses the register-file state at the accepting edge, plus the bypass.
- Reset deasserted mid-stream: the first accept takes place on the first rising edge with rst_n=1.

## Structure
- Shared package cpu_pkg:
  - ALU_control codes (AND/OR/ADD/SUB/NOR/NAND/COMP)
  - bonus_control codes (SLT 000, SGT 001, SLE 010, SGE 011, SNE 100, SLTU 101, SEQ 110)
  - opcode/funct constants
  - ID/EX bundle typedef
- Sub-module reg_file: 32x32, two async read ports, one sync write port, R[0] hardwired, bypass inside.
- Decode stays combinational inside id_ex_stage, feeding the ID/EX register.

## Test plan
- Reset then wb writes R1=5, R2=7 then add r3,r1,r2 -> ex_src1=5, ex_src2=7, ex_alu_ctrl=0010, ex_rd=3, ex_we=1, ex_valid=1 one cycle later.
- addi r4,r1,-1 (imm 0xFFFF) -> ex_src2=0xFFFFFFFF; andi with 0xFFFF -> ex_src2=0x0000FFFF; sltu -> 0111/101.
- wb_en=1, wb_addr=1, wb_data=0xDEADBEEF in the same cycle as reading rs=1 -> ex_src1=0xDEADBEEF. A write to R0 is followed by a read of R0, which returns 0.
- Stall held 3 cycles with a new instr presented -> ex_* unchanged, id_ready=0; after release the new instr loads.
- Flush asserted together with stall -> ex_valid=0 next cycle. Undefined funct 0x3F -> illegal=1 for one cycle, ex_valid=0.
- Async reset asserted mid-stream between edges -> ex_valid, ex_we and all ex_* go to 0 immediately, and all registers read 0 afterward.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU/bonus control codes, opcode/funct constants and the ID/EX bundle type.
package cpu_pkg;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0110,
      ALU_COMP = 4'b0111,
      ALU_NOR  = 4'b1100,
      ALU_NAND = 4'b1101
   } alu_ctrl_e;
   typedef enum logic [2:0] {
      B_SLT  = 3'b000,
      B_SGT  = 3'b001,
      B_SLE  = 3'b010,
      B_SGE  = 3'b011,
      B_SNE  = 3'b100,
      B_SLTU = 3'b101,
      B_SEQ  = 3'b110
   } bonus_ctrl_e;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] src1;
      logic [XLEN-1:0] src2;
      alu_ctrl_e       alu;
      bonus_ctrl_e     bonus;
      logic [AW-1:0]   rd;
      logic            we;
   } idex_t;
   function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
      return {{(XLEN-16){imm[15]}}, imm};
   endfunction
endpackage

// File: rtl/id_ex_stage_reg_file.sv
// reg_file: 32x32 register file, two async read ports with write-before-read bypass, R0 hardwired to zero.
module reg_file
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs_addr,
   input  logic [AW-1:0]   rt_addr,
   output logic [XLEN-1:0] rs_data,
   output logic [XLEN-1:0] rt_data,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data
);
   logic [XLEN-1:0] r_mem [NREG];
   logic            w_wr;
   assign w_wr = wb_en && (wb_addr != '0);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (w_wr) begin
         r_mem[wb_addr] <= wb_data;
      end
   end
   assign rs_data = (rs_addr == '0) ? '0 : (w_wr && wb_addr == rs_addr) ? wb_data : r_mem[rs_addr];
   assign rt_data = (rt_addr == '0) ? '0 : (w_wr && wb_addr == rt_addr) ? wb_data : r_mem[rt_addr];
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decodes one instruction per cycle, reads operands and registers the ID/EX bundle for the ALU.
module id_ex_stage
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [31:0]     instr,
   input  logic            stall,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_src1,
   output logic [XLEN-1:0] ex_src2,
   output logic [3:0]      ex_alu_ctrl,
   output logic [2:0]      ex_bonus_ctrl,
   output logic [AW-1:0]   ex_rd,
   output logic            ex_we,
   output logic            illegal
);
   logic [5:0]      w_op, w_fn;
   logic [AW-1:0]   w_rs, w_rt, w_rd;
   logic [15:0]     w_imm;
   logic [XLEN-1:0] w_rs_data, w_rt_data;
   logic            w_legal;
   idex_t           w_dec, r_ex;
   logic            r_illegal;
   assign w_op  = instr[31:26];
   assign w_rs  = instr[25:21];
   assign w_rt  = instr[20:16];
   assign w_rd  = instr[15:11];
   assign w_fn  = instr[5:0];
   assign w_imm = instr[15:0];
   reg_file u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .rs_addr (w_rs),
      .rt_addr (w_rt),
      .rs_data (w_rs_data),
      .rt_data (w_rt_data),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );
   always_comb begin
      w_dec       = '0;
      w_legal     = 1'b1;
      w_dec.src1  = w_rs_data;
      w_dec.src2  = w_rt_data;
      w_dec.rd    = w_rt;
      w_dec.alu   = ALU_ADD;
      w_dec.bonus = B_SLT;
      case (w_op)
         OP_RTYPE: begin
            w_dec.rd = w_rd;
            case (w_fn)
               FN_ADD:  w_dec.alu = ALU_ADD;
               FN_SUB:  w_dec.alu = ALU_SUB;
               FN_AND:  w_dec.alu = ALU_AND;
               FN_OR:   w_dec.alu = ALU_OR;
               FN_NOR:  w_dec.alu = ALU_NOR;
               FN_SLT:  w_dec.alu = ALU_COMP;
               FN_SLTU: begin
                  w_dec.alu   = ALU_COMP;
                  w_dec.bonus = B_SLTU;
               end
               default: w_legal = 1'b0;
            endcase
         end
         OP_ADDI: w_dec.src2 = sext16(w_imm);
         OP_SLTI: begin
            w_dec.alu  = ALU_COMP;
            w_dec.src2 = sext16(w_imm);
         end
         OP_ANDI: begin
            w_dec.alu  = ALU_AND;
            w_dec.src2 = {16'h0, w_imm};
         end
         OP_ORI: begin
            w_dec.alu  = ALU_OR;
            w_dec.src2 = {16'h0, w_imm};
         end
         default: w_legal = 1'b0;
      endcase
      w_dec.valid = w_legal;
      w_dec.we    = w_legal && (w_dec.rd != '0);
   end
   // flush beats stall; an illegal or absent instruction loads an all-zero bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex      <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= id_valid && !stall && !flush && !w_legal;
         if (flush) r_ex <= '0;
         else if (!stall) r_ex <= (id_valid && w_legal) ? w_dec : '0;
      end
   end
   assign id_ready      = ~stall;
   assign ex_valid      = r_ex.valid;
   assign ex_src1       = r_ex.src1;
   assign ex_src2       = r_ex.src2;
   assign ex_alu_ctrl   = r_ex.alu;
   assign ex_bonus_ctrl = r_ex.bonus;
   assign ex_rd         = r_ex.rd;
   assign ex_we         = r_ex.we;
   assign illegal       = r_illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of decode, operand bypass, stall/flush, illegal and async reset.
module tb_id_ex_stage;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        id_valid = 1'b0, stall = 1'b0, flush = 1'b0, wb_en = 1'b0;
   logic [31:0] instr = '0, wb_data = '0;
   logic [4:0]  wb_addr = '0;
   logic        id_ready, ex_valid, ex_we, illegal;
   logic [31:0] ex_src1, ex_src2;
   logic [3:0]  ex_alu_ctrl;
   logic [2:0]  ex_bonus_ctrl;
   logic [4:0]  ex_rd;
   int          n_cmp = 0, n_err = 0;
   id_ex_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_ready      (id_ready),
      .instr         (instr),
      .stall         (stall),
      .flush         (flush),
      .wb_en         (wb_en),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .ex_valid      (ex_valid),
      .ex_src1       (ex_src1),
      .ex_src2       (ex_src2),
      .ex_alu_ctrl   (ex_alu_ctrl),
      .ex_bonus_ctrl (ex_bonus_ctrl),
      .ex_rd         (ex_rd),
      .ex_we         (ex_we),
      .illegal       (illegal)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] rt_i(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction
   function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   initial begin
      #2;
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_src1", ex_src1, 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_ready", 32'(id_ready), 32'd1);
      rst_n = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
      tick();
      wb_addr = 5'd2; wb_data = 32'd7;
      tick();
      wb_en = 1'b0;
      id_valid = 1'b1; instr = rt_i(5'd1, 5'd2, 5'd3, 6'h20);
      tick();
      chk("add_src1", ex_src1, 32'd5);
      chk("add_src2", ex_src2, 32'd7);
      chk("add_alu", 32'(ex_alu_ctrl), 32'b0010);
      chk("add_bonus", 32'(ex_bonus_ctrl), 32'b000);
      chk("add_rd", 32'(ex_rd), 32'd3);
      chk("add_we", 32'(ex_we), 32'd1);
      chk("add_valid", 32'(ex_valid), 32'd1);
      instr = it_i(6'h08, 5'd1, 5'd4, 16'hFFFF);
      tick();
      chk("addi_src2", ex_src2, 32'hFFFFFFFF);
      chk("addi_alu", 32'(ex_alu_ctrl), 32'b0010);
      chk("addi_rd", 32'(ex_rd), 32'd4);
      instr = it_i(6'h0C, 5'd2, 5'd5, 16'hFFFF);
      tick();
      chk("andi_src2", ex_src2, 32'h0000FFFF);
      chk("andi_src1", ex_src1, 32'd7);
      chk("andi_alu", 32'(ex_alu_ctrl), 32'b0000);
      instr = rt_i(5'd1, 5'd2, 5'd6, 6'h2B);
      tick();
      chk("sltu_alu", 32'(ex_alu_ctrl), 32'b0111);
      chk("sltu_bonus", 32'(ex_bonus_ctrl), 32'b101);
      instr = rt_i(5'd1, 5'd2, 5'd0, 6'h22);
      tick();
      chk("dest0_we", 32'(ex_we), 32'd0);
      chk("dest0_valid", 32'(ex_valid), 32'd1);
      chk("sub_alu", 32'(ex_alu_ctrl), 32'b0110);
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEADBEEF;
      instr = rt_i(5'd1, 5'd2, 5'd7, 6'h25);
      tick();
      chk("bypass_src1", ex_src1, 32'hDEADBEEF);
      chk("or_alu", 32'(ex_alu_ctrl), 32'b0001);
      wb_en = 1'b0;
      instr = rt_i(5'd2, 5'd1, 5'd8, 6'h24);
      tick();
      chk("stored_src2", ex_src2, 32'hDEADBEEF);
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
      instr = rt_i(5'd0, 5'd0, 5'd9, 6'h20);
      tick();
      chk("r0_bypass", ex_src1, 32'd0);
      wb_en = 1'b0;
      tick();
      chk("r0_read1", ex_src1, 32'd0);
      chk("r0_read2", ex_src2, 32'd0);
      stall = 1'b1; instr = rt_i(5'd1, 5'd2, 5'd10, 6'h27);
      #1;
      chk("stall_ready", 32'(id_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_rd", 32'(ex_rd), 32'd9);
         chk("stall_alu", 32'(ex_alu_ctrl), 32'b0010);
         chk("stall_illegal", 32'(illegal), 32'd0);
      end
      stall = 1'b0;
      tick();
      chk("post_stall_rd", 32'(ex_rd), 32'd10);
      chk("nor_alu", 32'(ex_alu_ctrl), 32'b1100);
      chk("nor_src1", ex_src1, 32'hDEADBEEF);
      stall = 1'b1; flush = 1'b1;
      tick();
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_we", 32'(ex_we), 32'd0);
      stall = 1'b0; flush = 1'b0;
      instr = it_i(6'h0A, 5'd2, 5'd11, 16'h8000);
      tick();
      chk("slti_src2", ex_src2, 32'hFFFF8000);
      chk("slti_alu", 32'(ex_alu_ctrl), 32'b0111);
      chk("slti_rd", 32'(ex_rd), 32'd11);
      instr = rt_i(5'd1, 5'd2, 5'd3, 6'h3F);
      tick();
      chk("illegal_pulse", 32'(illegal), 32'd1);
      chk("illegal_valid", 32'(ex_valid), 32'd0);
      instr = rt_i(5'd1, 5'd2, 5'd3, 6'h2A);
      tick();
      chk("illegal_clear", 32'(illegal), 32'd0);
      chk("slt_valid", 32'(ex_valid), 32'd1);
      id_valid = 1'b0;
      tick();
      chk("bubble_valid", 32'(ex_valid), 32'd0);
      id_valid = 1'b1; instr = it_i(6'h0D, 5'd2, 5'd12, 16'h00F0);
      tick();
      chk("ori_src2", ex_src2, 32'h000000F0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(ex_valid), 32'd0);
      chk("arst_we", 32'(ex_we), 32'd0);
      chk("arst_src2", ex_src2, 32'd0);
      chk("arst_rd", 32'(ex_rd), 32'd0);
      rst_n = 1'b1;
      instr = rt_i(5'd1, 5'd2, 5'd13, 6'h20);
      tick();
      chk("post_rst_valid", 32'(ex_valid), 32'd1);
      chk("post_rst_src1", ex_src1, 32'd0);
      chk("post_rst_src2", ex_src2, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
